nios2_pio_gpio: RTL and testbench
=================================

# nios2_pio_gpio

Parametrised Avalon-MM general-purpose I/O slave for the Nios II system, successor to the fixed 7-bit output-only PIO. Provides per-bit direction control, a synchronised input path with edge capture, and a maskable level interrupt to the CPU. It sits on the Qsys interconnect as a single 32-bit slave with a 3-bit word address.

## Interface
- WIDTH, 8: number of I/O bits, legal range 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- DIR_RESET, 0: reset value of the direction register; 1 = output.
- EDGE_TYPE, 2: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: depth of the input synchroniser, legal range 2..4.
- clk  in  1  system clock; all logic is in this one domain.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  direction register, driven to the pad enables.
- irq  out  1  level interrupt.

## Operation
- Register map by word address:
  - 0 DATA: write loads out_port. Read returns, per bit, out_port where oe=1 and the synchronised input where oe=0.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns the capture bits; write-1-to-clear.
  - 4 OUTSET and 5 OUTCLEAR: see Configuration.
  - 6, 7: reads return 0; writes are ignored.
- A write is chipselect && !write_n. Writes take effect at the next clk edge.
- Input path: in_port passes through a SYNC_STAGES flop chain, then one delay register. The edge pulse compares the last sync stage with the delay register according to EDGE_TYPE.
- EDGECAP bit sets on an edge pulse and clears on a write of 1 to that bit. If an edge and a clear coincide on a bit, the set wins.
- Edges are captured on every bit regardless of DIR.
- Warm-up counter: after reset release, edge capture is suppressed for SYNC_STAGES+1 cycles while the chain fills. This prevents a false edge from a pin held high through reset.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Reset values:
  - out_port = RESET_VALUE, oe = DIR_RESET.
  - IRQMASK = 0, EDGECAP = 0, irq = 0, readdata = 0.
  - Sync chain and delay register = 0; warm-up counter = 0.
- Assertion of reset mid-operation clears all state immediately and restarts warm-up.

## Timing
- Read latency is 1 cycle. readdata is registered from address at each clk edge while chipselect=1 and write_n=1, and holds otherwise.
- A write to DATA or DIR is visible on out_port/oe one cycle after the write edge.
- Pin change to EDGECAP set: the first clk edge sampling the new level is edge k. The capture bit is set at edge k+SYNC_STAGES, and irq rises in the same cycle if the mask bit is set.
- A DATA read returns the input SYNC_STAGES cycles after the pin changes.
- Writing 1 to EDGECAP deasserts irq the cycle after the write edge, unless a new edge lands on that bit in that cycle.

## Configuration
- Macro PIO_SETCLR_EN.
- Defined:
  - A write to address 4 performs out_port |= writedata[WIDTH-1:0].
  - A write to address 5 performs out_port &= ~writedata[WIDTH-1:0].
  - Both are single-cycle atomic updates; reads of 4 and 5 return 0.
- Undefined: addresses 4 and 5 behave like 6 and 7, and the set/clear logic is absent.

## Structure
- Package nios2_pio_pkg holds:
  - address constants ADDR_DATA through ADDR_OUTCLEAR;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants;
  - the readdata zero-extension helper.
- Sub-module pio_sync_edge: WIDTH-bit synchroniser, delay register, warm-up counter, and edge-pulse output, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE.
- The top level holds the register file, read mux and irq.

## Test plan
- Reset with in_port=8'hFF and EDGE_TYPE=0 -> out_port=RESET_VALUE, oe=DIR_RESET, EDGECAP stays 0 after warm-up, irq=0.
- Write DIR=8'h0F, DATA=8'hA5, in_port=8'h30; read DATA -> 8'h35 on readdata one cycle after the read edge, and readdata[31:8]=0.
- IRQMASK=8'h01; in_port[0] goes 0->1 -> EDGECAP=8'h01 and irq=1 at SYNC_STAGES edges later; write EDGECAP=8'h01 -> irq=0 next cycle.
- A write-1-to-clear to bit 0 in the same cycle as a new bit-0 edge pulse -> bit 0 remains 1 and irq stays high.
- With PIO_SETCLR_EN: DATA=8'h0F, write 4 with 8'h30, then 5 with 8'h03 -> out_port=8'h3C. Without the macro: out_port stays 8'h0F.
- Assert reset for one cycle mid-capture with EDGECAP=8'hFF -> all registers return to reset values asynchronously, and no capture occurs during the following SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/nios2_pio_pkg.sv
// Shared constants and helpers for the Nios II PIO/GPIO slave.
// Word address map, edge selectors, readdata zero-extension.
package nios2_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Keep only the low w bits so unused lanes read back as 0.
  function automatic logic [31:0] rd_zext(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF
                  : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, delay register and gated edge detector.
// Capture is held off until the chain has filled after reset.
module pio_sync_edge
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int WARM = SYNC_STAGES + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;
  logic [2:0]       warm_q;
  logic             warm_done;
  logic [WIDTH-1:0] raw;

  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == 3'(WARM));

  // Shift pins through the chain, then one extra delay stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      dly_q <= sync_in;
    end
  end

  // Count the fill cycles after reset, saturating when done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      warm_q <= '0;
    else if (!warm_done)
      warm_q <= warm_q + 3'd1;
  end

  // Select the edge polarity that raises a capture pulse.
  always_comb begin
    raw = sync_in & ~dly_q;
    if (EDGE_TYPE == EDGE_FALLING)
      raw = ~sync_in & dly_q;
    else if (EDGE_TYPE == EDGE_ANY)
      raw = sync_in ^ dly_q;
  end

  assign edge_pulse = raw & {WIDTH{warm_done}};

endmodule

// File: rtl/nios2_pio_gpio.sv
// Avalon-MM GPIO slave: data, direction, irq mask, edge capture.
// Define PIO_SETCLR_EN for atomic OUTSET/OUTCLEAR at words 4/5.
module nios2_pio_gpio
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 2,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] pulse;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_val;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign clr       = (wr && address == ADDR_EDGECAP)
                   ? wd : '0;
  assign irq       = |(cap_q & mask_q);

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (pulse)
  );

  // Register file writes; set/clear words only when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= RESET_VALUE;
      oe       <= DIR_RESET;
      mask_q   <= '0;
    end else if (wr) begin
      unique case (1'b1)
        (address == ADDR_DATA):    out_port <= wd;
        (address == ADDR_DIR):     oe       <= wd;
        (address == ADDR_IRQMASK): mask_q   <= wd;
`ifdef PIO_SETCLR_EN
        (address == ADDR_OUTSET):
          out_port <= out_port | wd;
        (address == ADDR_OUTCLEAR):
          out_port <= out_port & ~wd;
`endif
        default: ;
      endcase
    end
  end

  // Edge capture: write-1 clears, a same-cycle edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cap_q <= '0;
    else
      cap_q <= (cap_q & ~clr) | pulse;
  end

  // Read mux; DATA mixes driven and sampled bits by direction.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (address == ADDR_DATA):
        rd_val = 32'((out_port & oe) | (sync_in & ~oe));
      (address == ADDR_DIR):     rd_val = 32'(oe);
      (address == ADDR_IRQMASK): rd_val = 32'(mask_q);
      (address == ADDR_EDGECAP): rd_val = 32'(cap_q);
      default:                   rd_val = '0;
    endcase
  end

  // Registered read data, held while no read is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else if (rd)
      readdata <= rd_zext(rd_val, WIDTH);
  end

endmodule

// File: tb/tb_nios2_pio_gpio.sv
// Directed bench for nios2_pio_gpio (WIDTH=8, rising edge).
// Expected values are hand-computed in the stimulus below.
module tb_nios2_pio_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  nios2_pio_gpio #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00),
    .DIR_RESET   (8'h00),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(
    input logic [2:0]  a,
    input logic [31:0] d
  );
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  logic [7:0] exp_sc;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    ticks(2);
    chk("rst_out", 32'(out_port), 32'h00);
    chk("rst_oe", 32'(oe), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", readdata, 32'h0);

    reset = 1'b0;
    ticks(6);
    bus_rd(3'd3);
    chk("warm_cap", readdata, 32'h0);
    chk("warm_irq", 32'(irq), 32'h0);

    bus_wr(3'd1, 32'hFFFF_FF0F);
    bus_wr(3'd0, 32'h0000_00A5);
    chk("dir_out", 32'(oe), 32'h0F);
    chk("data_out", 32'(out_port), 32'hA5);
    in_port = 8'h30;
    ticks(3);
    bus_rd(3'd0);
    chk("data_rd", readdata, 32'h35);
    chk("data_hi0", 32'(readdata[31:8]), 32'h0);
    address = 3'd1;
    tick();
    chk("rd_hold", readdata, 32'h35);
    bus_rd(3'd1);
    chk("dir_rd", readdata, 32'h0F);
    bus_rd(3'd3);
    chk("fall_nocap", readdata, 32'h0);

    bus_wr(3'd2, 32'h01);
    bus_rd(3'd2);
    chk("mask_rd", readdata, 32'h01);
    in_port = 8'h31;
    tick();
    chk("irq_k", 32'(irq), 32'h0);
    tick();
    chk("irq_k1", 32'(irq), 32'h0);
    tick();
    chk("irq_k2", 32'(irq), 32'h1);
    bus_rd(3'd3);
    chk("cap_rd", readdata, 32'h01);
    bus_wr(3'd3, 32'h01);
    chk("clr_irq", 32'(irq), 32'h0);

    in_port = 8'h30;
    ticks(4);
    in_port = 8'h31;
    tick();
    in_port = 8'h30;
    tick();
    in_port = 8'h31;
    tick();
    chk("pre_irq", 32'(irq), 32'h1);
    tick();
    bus_wr(3'd3, 32'h01);
    chk("setwin_irq", 32'(irq), 32'h1);
    bus_rd(3'd3);
    chk("setwin_cap", readdata, 32'h01);
    bus_wr(3'd3, 32'h01);
    chk("clr2_irq", 32'(irq), 32'h0);

    bus_wr(3'd0, 32'h0F);
    bus_wr(3'd4, 32'h30);
    bus_wr(3'd5, 32'h03);
`ifdef PIO_SETCLR_EN
    exp_sc = 8'h3C;
`else
    exp_sc = 8'h0F;
`endif
    chk("setclr", 32'(out_port), 32'(exp_sc));
    bus_wr(3'd6, 32'hFF);
    chk("wr6_ign", 32'(out_port), 32'(exp_sc));
    bus_rd(3'd4);
    chk("rd4_zero", readdata, 32'h0);
    bus_rd(3'd6);
    chk("rd6_zero", readdata, 32'h0);

    in_port = 8'h00;
    ticks(4);
    in_port = 8'hFF;
    ticks(4);
    bus_wr(3'd2, 32'hFF);
    bus_rd(3'd3);
    chk("cap_ff", readdata, 32'hFF);
    chk("irq_ff", 32'(irq), 32'h1);

    reset = 1'b1;
    #1;
    chk("arst_out", 32'(out_port), 32'h00);
    chk("arst_oe", 32'(oe), 32'h00);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", readdata, 32'h0);
    tick();
    reset = 1'b0;
    bus_wr(3'd2, 32'hFF);
    ticks(5);
    chk("rewarm_irq", 32'(irq), 32'h0);
    bus_rd(3'd3);
    chk("rewarm_cap", readdata, 32'h0);
    bus_rd(3'd2);
    chk("rewarm_mask", readdata, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
